// File: rtl/red_bbox_pkg.sv
// Shared widths, default frame geometry and tracker state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package red_bbox_pkg;
    localparam int COORD_W     = 11;
    localparam int COUNT_W     = 20;
    localparam int RUN_W       = 4;
    localparam int DEF_IMAGE_W = 640;
    localparam int DEF_IMAGE_H = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_t;
endpackage

// File: rtl/red_run_filter.sv
// Horizontal run-length filter: flags red pixels that belong to a run of at least MIN_RUN.
// Latency: combinational strobes for the current beat; run counter updates on the beat's edge.
// Backpressure: none; only advances on pix_vld, so stalls simply hold the run.
// Ports: pix_vld (beat counted as a frame pixel), line_start (beat is column 0),
//        red_sector (pixel class), qualify (pixel is in a long-enough run),
//        first_qualify (this beat is where the run first reaches MIN_RUN).
module red_run_filter
    import red_bbox_pkg::*;
#(
    parameter int MIN_RUN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pix_vld,
    input  logic line_start,
    input  logic red_sector,
    output logic qualify,
    output logic first_qualify
);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MIN_RUN);
    localparam logic [RUN_W-1:0] RUN_PREV = RUN_W'(MIN_RUN - 1);

    logic [RUN_W-1:0] run_q, run_d, run_cur;

    always_comb begin
        // A line start discards whatever run the previous line ended with.
        run_cur       = line_start ? '0 : run_q;
        run_d         = run_q;
        qualify       = 1'b0;
        first_qualify = 1'b0;
        if (pix_vld) begin
            if (red_sector) begin
                run_d         = (run_cur == RUN_MAX) ? RUN_MAX : run_cur + 1'b1;
                qualify       = (run_d == RUN_MAX);
                first_qualify = (run_cur == RUN_PREV);
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) run_q <= '0;
        else          run_q <= run_d;
    end
endmodule

// File: rtl/red_bbox_tracker.sv
// Per-frame bounding box of run-filtered red pixels, published once per completed frame.
// Latency: box registered on the edge after the last pixel's edge; bbox_valid pulses one cycle.
// Backpressure: none; in_valid low or non-video beats freeze all state, stalls of any length ok.
// Ports: in_valid/sop/packet_video/red_sector (pixel stream), bbox_* (box of last commit),
//        bbox_found, pixel_count, bbox_valid (commit strobe), frame_count (commits, wrapping).
module red_bbox_tracker
    import red_bbox_pkg::*;
#(
    parameter int IMAGE_W   = DEF_IMAGE_W,
    parameter int IMAGE_H   = DEF_IMAGE_H,
    parameter int MIN_RUN   = 4,
    parameter int MIN_COUNT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic               sop,
    input  logic               packet_video,
    input  logic               red_sector,
    output logic [COORD_W-1:0] bbox_left,
    output logic [COORD_W-1:0] bbox_right,
    output logic [COORD_W-1:0] bbox_top,
    output logic [COORD_W-1:0] bbox_bottom,
    output logic               bbox_found,
    output logic [COUNT_W-1:0] pixel_count,
    output logic               bbox_valid,
    output logic [15:0]        frame_count
);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMAGE_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(IMAGE_H - 1);
    localparam logic [COORD_W-1:0] RUN_BACK  = COORD_W'(MIN_RUN - 1);
    localparam logic [COUNT_W:0]   INC_FIRST = (COUNT_W + 1)'(MIN_RUN);
    localparam logic [COUNT_W:0]   INC_ONE   = (COUNT_W + 1)'(1);
    localparam logic [COUNT_W-1:0] MIN_CNT   = COUNT_W'(MIN_COUNT);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [COORD_W-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COORD_W-1:0] left_q, left_d, right_q, right_d, top_q, top_d, bottom_q, bottom_d;
    logic               found_q, found_d, valid_q, valid_d;
    logic [COUNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               acc_beat, start_beat, pix_vld, last_pix;
    logic               qualify, first_qualify;
    logic [COORD_W-1:0] x_cur, y_cur, x_first;
    logic [COUNT_W:0]   cnt_sum;

    // A sop beat is pixel (0,0) in any state, which covers both the abort
    // (sop while ACTIVE) and the back-to-back (sop during COMMIT) cases.
    assign acc_beat   = in_valid && packet_video;
    assign start_beat = acc_beat && sop;
    assign pix_vld    = start_beat || (acc_beat && (state_q == ACTIVE));
    assign x_cur      = start_beat ? '0 : x_q;
    assign y_cur      = start_beat ? '0 : y_q;
    assign last_pix   = (x_cur == X_LAST) && (y_cur == Y_LAST);
    assign x_first    = x_cur - RUN_BACK;

    red_run_filter #(.MIN_RUN(MIN_RUN)) u_run_filter (
        .clk           (clk),
        .reset_n       (reset_n),
        .pix_vld       (pix_vld),
        .line_start    (x_cur == '0),
        .red_sector    (red_sector),
        .qualify       (qualify),
        .first_qualify (first_qualify)
    );

    always_comb begin
        state_d = (state_q == COMMIT) ? IDLE : state_q;
        if (pix_vld) state_d = last_pix ? COMMIT : ACTIVE;
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        min_x_d = start_beat ? '1 : min_x_q;
        max_x_d = start_beat ? '0 : max_x_q;
        min_y_d = start_beat ? '1 : min_y_q;
        max_y_d = start_beat ? '0 : max_y_q;
        count_d = start_beat ? '0 : count_q;
        cnt_sum = '0;
        if (pix_vld) begin
            if (x_cur == X_LAST) begin
                x_d = '0;
                y_d = y_cur + 1'b1;
            end else begin
                x_d = x_cur + 1'b1;
                y_d = y_cur;
            end
            if (qualify) begin
                // Only the run's first qualifying beat can lower min_x: it
                // retroactively admits the MIN_RUN-1 pixels behind it.
                if (first_qualify && (x_first < min_x_d)) min_x_d = x_first;
                if (x_cur > max_x_d) max_x_d = x_cur;
                if (y_cur < min_y_d) min_y_d = y_cur;
                if (y_cur > max_y_d) max_y_d = y_cur;
                cnt_sum = {1'b0, count_d} + (first_qualify ? INC_FIRST : INC_ONE);
                count_d = cnt_sum[COUNT_W] ? '1 : cnt_sum[COUNT_W-1:0];
            end
        end
    end

    always_comb begin
        left_d      = left_q;
        right_d     = right_q;
        top_d       = top_q;
        bottom_d    = bottom_q;
        found_d     = found_q;
        pix_cnt_d   = pix_cnt_q;
        frame_cnt_d = frame_cnt_q;
        valid_d     = 1'b0;
        if (state_q == COMMIT) begin
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 1'b1;
            pix_cnt_d   = count_q;
            found_d     = (count_q >= MIN_CNT);
            left_d      = found_d ? min_x_q : '0;
            right_d     = found_d ? max_x_q : '0;
            top_d       = found_d ? min_y_q : '0;
            bottom_d    = found_d ? max_y_q : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            min_x_q     <= '1;
            max_x_q     <= '0;
            min_y_q     <= '1;
            max_y_q     <= '0;
            count_q     <= '0;
            left_q      <= '0;
            right_q     <= '0;
            top_q       <= '0;
            bottom_q    <= '0;
            found_q     <= 1'b0;
            pix_cnt_q   <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            min_x_q     <= min_x_d;
            max_x_q     <= max_x_d;
            min_y_q     <= min_y_d;
            max_y_q     <= max_y_d;
            count_q     <= count_d;
            left_q      <= left_d;
            right_q     <= right_d;
            top_q       <= top_d;
            bottom_q    <= bottom_d;
            found_q     <= found_d;
            pix_cnt_q   <= pix_cnt_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bbox_left   = left_q;
    assign bbox_right  = right_q;
    assign bbox_top    = top_q;
    assign bbox_bottom = bottom_q;
    assign bbox_found  = found_q;
    assign pixel_count = pix_cnt_q;
    assign bbox_valid  = valid_q;
    assign frame_count = frame_cnt_q;
endmodule

// File: tb/tb_red_bbox_tracker.sv
// Randomised frame stimulus against a row-segment reference model of the box tracker.
// Latency: expects the commit strobe one cycle after the last pixel's edge.
// Backpressure: injects in_valid gaps and non-video beats between pixels.
module tb_red_bbox_tracker;
    localparam int IMG_W   = 32;
    localparam int IMG_H   = 16;
    localparam int MIN_RUN = 4;
    localparam int MIN_CNT = 16;

    typedef struct {
        int due;
        int l;
        int r;
        int t;
        int b;
        int found;
        int cnt;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        sop = 1'b0;
    logic        packet_video = 1'b0;
    logic        red_sector = 1'b0;
    logic [10:0] bbox_left, bbox_right, bbox_top, bbox_bottom;
    logic        bbox_found, bbox_valid;
    logic [19:0] pixel_count;
    logic [15:0] frame_count;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   fc_exp = 0;
    logic ev;
    rec_t hold;
    rec_t exp_q[$];
    bit   redmap [IMG_H][IMG_W];

    red_bbox_tracker #(
        .IMAGE_W(IMG_W), .IMAGE_H(IMG_H), .MIN_RUN(MIN_RUN), .MIN_COUNT(MIN_CNT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .sop(sop),
        .packet_video(packet_video), .red_sector(red_sector),
        .bbox_left(bbox_left), .bbox_right(bbox_right), .bbox_top(bbox_top),
        .bbox_bottom(bbox_bottom), .bbox_found(bbox_found), .pixel_count(pixel_count),
        .bbox_valid(bbox_valid), .frame_count(frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: each maximal red segment of a row qualifies whole if it is at
    // least MIN_RUN long; segments are cut at row boundaries.
    function automatic rec_t model();
        rec_t m;
        int cnt = 0, l = 2047, r = 0, t = 2047, b = 0;
        for (int y = 0; y < IMG_H; y++) begin
            int x = 0;
            while (x < IMG_W) begin
                if (!redmap[y][x]) begin
                    x++;
                end else begin
                    int s = x;
                    while (x < IMG_W && redmap[y][x]) x++;
                    if (x - s >= MIN_RUN) begin
                        cnt += x - s;
                        if (s < l) l = s;
                        if (x - 1 > r) r = x - 1;
                        if (y < t) t = y;
                        if (y > b) b = y;
                    end
                end
            end
        end
        m = '{default: 0};
        m.cnt   = cnt;
        m.found = (cnt >= MIN_CNT) ? 1 : 0;
        if (m.found == 1) begin
            m.l = l; m.r = r; m.t = t; m.b = b;
        end
        return m;
    endfunction

    task automatic clear_map();
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) redmap[y][x] = 1'b0;
    endtask

    task automatic set_run(input int y, input int x0, input int len);
        for (int x = x0; x < x0 + len && x < IMG_W; x++) redmap[y][x] = 1'b1;
    endtask

    // maxlen<=3 gives only sub-threshold noise
    task automatic random_map(input int maxlen);
        clear_map();
        for (int y = 0; y < IMG_H; y++) begin
            int x = int'($urandom_range(0, 5));
            while (x < IMG_W) begin
                int len = int'($urandom_range(1, maxlen));
                set_run(y, x, len);
                x += len + int'($urandom_range(1, 6));
            end
        end
    endtask

    task automatic send_frame(input int npix, input bit gaps, input bit with_sop);
        rec_t m;
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid     = 1'($urandom_range(0, 1));
                    packet_video = 1'b0;
                    sop          = 1'($urandom_range(0, 1));
                    red_sector   = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            in_valid     = 1'b1;
            packet_video = 1'b1;
            sop          = with_sop && (i == 0);
            red_sector   = redmap[i / IMG_W][i % IMG_W];
            @(posedge clk); #1;
        end
        in_valid = 1'b0; packet_video = 1'b0; sop = 1'b0; red_sector = 1'b0;
        if (with_sop && npix == IMG_W * IMG_H) begin
            m = model();
            m.due = cyc + 1;
            exp_q.push_back(m);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        hold   = '{default: 0};
        fc_exp = 0;
        check("rst_left", 32'(bbox_left), 0);
        check("rst_right", 32'(bbox_right), 0);
        check("rst_top", 32'(bbox_top), 0);
        check("rst_bottom", 32'(bbox_bottom), 0);
        check("rst_found", 32'(bbox_found), 0);
        check("rst_count", 32'(pixel_count), 0);
        check("rst_valid", 32'(bbox_valid), 0);
        check("rst_frames", 32'(frame_count), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Every cycle: strobe and all held outputs against the model's last commit.
    always @(negedge clk) begin
        ev = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            hold = exp_q.pop_front();
            fc_exp++;
            ev = 1'b1;
        end
        check("bbox_valid", 32'(bbox_valid), 32'(ev));
        check("bbox_left", 32'(bbox_left), hold.l);
        check("bbox_right", 32'(bbox_right), hold.r);
        check("bbox_top", 32'(bbox_top), hold.t);
        check("bbox_bottom", 32'(bbox_bottom), hold.b);
        check("bbox_found", 32'(bbox_found), hold.found);
        check("pixel_count", 32'(pixel_count), hold.cnt);
        check("frame_count", 32'(frame_count), 32'(fc_exp[15:0]));
    end

    initial begin
        rec_t m;
        #2;
        do_reset();

        // Block of red x=20..29 on lines 5..8.
        clear_map();
        for (int y = 5; y <= 8; y++) set_run(y, 20, 10);
        m = model();
        check("model_box_left", m.l, 20);
        check("model_box_right", m.r, 29);
        check("model_box_top", m.t, 5);
        check("model_box_bottom", m.b, 8);
        check("model_box_count", m.cnt, 40);
        check("model_box_found", m.found, 1);
        send_frame(IMG_W * IMG_H, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("frames_after_box", 32'(frame_count), 1);

        // Reset in the middle of an active frame, then a sop-less frame.
        random_map(9);
        send_frame(100, 1'b1, 1'b1);
        do_reset();
        send_frame(IMG_W * IMG_H, 1'b1, 1'b0);
        repeat (4) @(posedge clk);

        // Sub-threshold noise only.
        random_map(3);
        m = model();
        check("model_noise_count", m.cnt, 0);
        send_frame(IMG_W * IMG_H, 1'b1, 1'b1);

        // Run straddling a line boundary: only the line-2 part qualifies.
        clear_map();
        set_run(2, IMG_W - 4, 4);
        set_run(3, 0, 2);
        m = model();
        check("model_wrap_count", m.cnt, 4);
        check("model_wrap_found", m.found, 0);
        send_frame(IMG_W * IMG_H, 1'b1, 1'b1);

        // Abort at line 10 by a fresh sop, with gaps and non-video beats.
        random_map(9);
        send_frame(10 * IMG_W, 1'b1, 1'b1);
        random_map(9);
        send_frame(IMG_W * IMG_H, 1'b1, 1'b1);

        // Back-to-back: second sop lands on the COMMIT cycle.
        random_map(9);
        send_frame(IMG_W * IMG_H, 1'b0, 1'b1);
        clear_map();
        for (int y = 0; y < 4; y++) set_run(y, 0, 6);
        m = model();
        check("model_b2b_left", m.l, 0);
        check("model_b2b_count", m.cnt, 24);
        send_frame(IMG_W * IMG_H, 1'b0, 1'b1);

        // Stray video beats in IDLE, then random frames.
        random_map(9);
        send_frame(40, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            random_map(k + 4);
            send_frame(IMG_W * IMG_H, 1'b1, 1'b1);
        end

        repeat (6) @(posedge clk);
        #1 check("pending_commits", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
